serial_sum_receiver: RTL

//  Receiving end of the bit-serial arithmetic link: accepts two operand streams LSB-first,
//  one bit pair per valid cycle, adds or subtracts them bit-serially and deserializes the

---
 rtl/serial_pkg.sv | 16 +
 rtl/fa_cell.sv | 15 +
 rtl/serial_sum_receiver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial receive path.
//   WIDTH_DEF : default operand/result width
//   CNT_W     : bit-count width for the default width
//   state_t   : receiver FSM states IDLE / RECV / DONE
package serial_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the serial arithmetic bit cell.
//   a, b, cin : operand bits and carry in
//   sum, cout : sum bit and carry out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sum_receiver.sv
// Bit-serial add/subtract receiver: takes two LSB-first operand streams, one bit pair per
// valid cycle, and deserializes the result into a parallel word with carry/not-borrow.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   sin_valid         : bit pair valid this cycle
//   sin_first         : marks bit 0 of a new frame
//   sin_a, sin_b      : operand serial bits
//   sub               : 0 add, 1 subtract; sampled with the first bit
//   pout, cout        : result word and carry / not-borrow, held between strobes
//   pout_valid        : one-cycle strobe when pout/cout update
//   busy              : frame in progress
//   frame_err         : one-cycle pulse when sin_first arrives mid-frame
//   ovf               : two's-complement overflow (only with SERIAL_RX_OVF_EN defined)
module serial_sum_receiver
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin_valid,
   input  logic             sin_first,
   input  logic             sin_a,
   input  logic             sin_b,
   input  logic             sub,
   output logic [WIDTH-1:0] pout,
   output logic             cout,
   output logic             pout_valid,
   output logic             busy,
`ifdef SERIAL_RX_OVF_EN
   output logic             frame_err,
   output logic             ovf
`else
   output logic             frame_err
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] pout_q, pout_d;
   logic             cout_q, cout_d;
   logic             ferr_q, ferr_d;
`ifdef SERIAL_RX_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic start, accept, last;
   logic sub_eff, fa_b, fa_cin, fa_sum, fa_cout;

   // sin_first always opens a new frame, whatever the state
   assign start   = sin_valid & sin_first;
   assign accept  = start | (sin_valid & (state_q == RECV));
   assign last    = sin_valid & ~sin_first & (state_q == RECV) &
                    (cnt_q == CntW'(WIDTH - 1));
   assign sub_eff = start ? sub : sub_q;
   assign fa_b    = sin_b ^ sub_eff;
   // carry seeded with 1 on subtract to complete the two's complement of B
   assign fa_cin  = start ? sub : carry_q;

   fa_cell u_fa (
      .a    (sin_a),
      .b    (fa_b),
      .cin  (fa_cin),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      work_d  = work_q;
      pout_d  = pout_q;
      cout_d  = cout_q;
      ferr_d  = start & (state_q == RECV);
`ifdef SERIAL_RX_OVF_EN
      ovf_d   = ovf_q;
`endif
      if (accept) begin
         carry_d = fa_cout;
         if (start) begin
            sub_d   = sub;
            cnt_d   = CntW'(1);
            work_d  = {fa_sum, {(WIDTH - 1){1'b0}}};
            state_d = RECV;
         end else if (last) begin
            pout_d  = {fa_sum, work_q[WIDTH-1:1]};
            cout_d  = fa_cout;
`ifdef SERIAL_RX_OVF_EN
            // carry_q is the carry into the MSB cell at this point
            ovf_d   = carry_q ^ fa_cout;
`endif
            cnt_d   = '0;
            state_d = DONE;
         end else begin
            work_d  = {fa_sum, work_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CntW'(1);
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         work_q  <= '0;
         pout_q  <= '0;
         cout_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_RX_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         work_q  <= work_d;
         pout_q  <= pout_d;
         cout_q  <= cout_d;
         ferr_q  <= ferr_d;
`ifdef SERIAL_RX_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign pout       = pout_q;
   assign cout       = cout_q;
   assign pout_valid = (state_q == DONE);
   assign busy       = (state_q == RECV);
   assign frame_err  = ferr_q;
`ifdef SERIAL_RX_OVF_EN
   assign ovf        = ovf_q;
`endif

endmodule
